// File: rtl/rx_link_fault_detect.sv
// XGMII receive link fault detector: classifies each 4-lane column as a local/remote
// fault sequence and tracks fault state. Define RX_LINK_FAULT_STAT_EN for episode counters.
module rx_link_fault_detect #(
    parameter int COL_WINDOW = 128,
    parameter int SEQ_THRESH = 4
) (
    input  logic        rxclk,
    input  logic        reset_n,
    input  logic [63:0] rxd64,
    input  logic [7:0]  rxc8,
    output logic [1:0]  link_fault,
    output logic        fault_change
`ifdef RX_LINK_FAULT_STAT_EN
    ,
    output logic [15:0] local_fault_cnt,
    output logic [15:0] remote_fault_cnt
`endif
);

    localparam int CW = $clog2(COL_WINDOW + 1);
    localparam int SW = $clog2(SEQ_THRESH + 1);
    localparam logic [CW-1:0] COL_WIN = CW'(COL_WINDOW);
    localparam logic [SW-1:0] SEQ_TH  = SW'(SEQ_THRESH);

    typedef enum logic [1:0] {ST_OK = 2'd0, ST_COUNT = 2'd1, ST_FAULT = 2'd2} state_t;

    // lf travels with the state so a fault declared in column A can be held
    // correctly if column B immediately starts a count of the other type.
    typedef struct packed {
        state_t          st;
        logic [1:0]      seq_type;
        logic [SW-1:0]   seq_cnt;
        logic [CW-1:0]   col_cnt;
        logic [1:0]      lf;
    } fsm_t;

    fsm_t cur, mid, nxt;

    // 2'b10 local, 2'b11 remote, 2'b00 not a fault sequence
    function automatic logic [1:0] col_type(input logic [31:0] d, input logic [3:0] c);
        col_type = 2'b00;
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01)      col_type = 2'b10;
            else if (d[31:24] == 8'h02) col_type = 2'b11;
        end
    endfunction

    function automatic fsm_t restart(input fsm_t s, input logic [1:0] t);
        fsm_t n;
        n          = s;
        n.seq_type = t;
        n.seq_cnt  = SW'(1);
        n.col_cnt  = '0;
        n.st       = (SEQ_THRESH <= 1) ? ST_FAULT : ST_COUNT;
        return n;
    endfunction

    function automatic fsm_t go_ok(input fsm_t s);
        fsm_t n;
        n          = s;
        n.st       = ST_OK;
        n.seq_type = 2'b00;
        n.seq_cnt  = '0;
        n.col_cnt  = '0;
        return n;
    endfunction

    function automatic fsm_t step(input fsm_t s, input logic [1:0] t);
        fsm_t n;
        n = s;
        case (s.st)
            ST_OK: begin
                if (t != 2'b00) n = restart(s, t);
            end
            ST_COUNT: begin
                n.col_cnt = (s.col_cnt == '1) ? s.col_cnt : s.col_cnt + CW'(1);
                if (t != 2'b00 && t == s.seq_type) begin
                    n.seq_cnt = (s.seq_cnt == '1) ? s.seq_cnt : s.seq_cnt + SW'(1);
                    if (n.seq_cnt >= SEQ_TH) begin
                        n.st      = ST_FAULT;
                        n.col_cnt = '0;
                    end
                end else if (t != 2'b00) begin
                    n = restart(s, t);
                end
                if (n.st == ST_COUNT && n.col_cnt >= COL_WIN) n = go_ok(n);
            end
            ST_FAULT: begin
                if (t != 2'b00 && t == s.seq_type) begin
                    n.col_cnt = '0;
                end else if (t != 2'b00) begin
                    n = restart(s, t);
                end else begin
                    n.col_cnt = (s.col_cnt == '1) ? s.col_cnt : s.col_cnt + CW'(1);
                    if (n.col_cnt >= COL_WIN) n = go_ok(n);
                end
            end
            default: n = go_ok(s);
        endcase
        // COUNT keeps whatever was being reported, so a type switch out of FAULT holds it
        n.lf = (n.st == ST_FAULT) ? n.seq_type : (n.st == ST_COUNT) ? s.lf : 2'b00;
        return n;
    endfunction

    always_comb begin
        mid = step(cur, col_type(rxd64[31:0],  rxc8[3:0]));
        nxt = step(mid, col_type(rxd64[63:32], rxc8[7:4]));
    end

    always_ff @(posedge rxclk) begin
        if (!reset_n) begin
            cur.st       <= ST_OK;
            cur.seq_type <= 2'b00;
            cur.seq_cnt  <= '0;
            cur.col_cnt  <= '0;
            cur.lf       <= 2'b00;
            fault_change <= 1'b0;
        end else begin
            cur          <= nxt;
            fault_change <= (nxt.lf != cur.lf);
        end
    end

    assign link_fault = cur.lf;

`ifdef RX_LINK_FAULT_STAT_EN
    logic       enter_a, enter_b;
    logic [1:0] loc_inc, rem_inc;

    function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        enter_a = (cur.st != ST_FAULT) && (mid.st == ST_FAULT);
        enter_b = (mid.st != ST_FAULT) && (nxt.st == ST_FAULT);
        loc_inc = {1'b0, enter_a && mid.seq_type == 2'b10} + {1'b0, enter_b && nxt.seq_type == 2'b10};
        rem_inc = {1'b0, enter_a && mid.seq_type == 2'b11} + {1'b0, enter_b && nxt.seq_type == 2'b11};
    end

    always_ff @(posedge rxclk) begin
        if (!reset_n) begin
            local_fault_cnt  <= '0;
            remote_fault_cnt <= '0;
        end else begin
            local_fault_cnt  <= sat_add(local_fault_cnt, loc_inc);
            remote_fault_cnt <= sat_add(remote_fault_cnt, rem_inc);
        end
    end
`endif

endmodule

// File: tb/tb_rx_link_fault_detect.sv
// Directed bench for rx_link_fault_detect: vector table plus window/threshold sequences.
module tb_rx_link_fault_detect;

    logic        rxclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] rxd64 = 64'h07070707_07070707;
    logic [7:0]  rxc8 = 8'hFF;
    logic [1:0]  link_fault;
    logic        fault_change;
`ifdef RX_LINK_FAULT_STAT_EN
    logic [15:0] local_fault_cnt, remote_fault_cnt;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [63:0] D_IDLE = 64'h07070707_07070707;
    localparam logic [63:0] D_LOC2 = 64'h0100009C_0100009C;
    localparam logic [63:0] D_REM2 = 64'h0200009C_0200009C;
    localparam logic [63:0] D_LOCA = 64'h07070707_0100009C;
    localparam logic [63:0] D_MAL3 = 64'h0300009C_0300009C;

    rx_link_fault_detect dut (
        .rxclk(rxclk), .reset_n(reset_n), .rxd64(rxd64), .rxc8(rxc8),
        .link_fault(link_fault), .fault_change(fault_change)
`ifdef RX_LINK_FAULT_STAT_EN
        , .local_fault_cnt(local_fault_cnt), .remote_fault_cnt(remote_fault_cnt)
`endif
    );

    always #5 rxclk = ~rxclk;

    typedef struct {
        logic        rst_n;
        logic [7:0]  c;
        logic [63:0] d;
        logic [1:0]  lf;
        logic        fc;
    } vec_t;

    vec_t tbl[22];

    task automatic apply(input logic r, input logic [7:0] c, input logic [63:0] d);
        @(negedge rxclk);
        reset_n = r;
        rxc8    = c;
        rxd64   = d;
        @(posedge rxclk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] elf, input logic efc);
        checks++;
        if (link_fault !== elf) begin
            failures++;
            $display("FAIL %s link_fault got=%b exp=%b", name, link_fault, elf);
        end
        checks++;
        if (fault_change !== efc) begin
            failures++;
            $display("FAIL %s fault_change got=%b exp=%b", name, fault_change, efc);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 8'hFF, D_IDLE, 2'b00, 1'b0};
        tbl[1]  = '{1'b0, 8'hFF, D_IDLE, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 8'h11, D_LOC2, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 8'h11, D_LOC2, 2'b10, 1'b1};
        tbl[4]  = '{1'b1, 8'h11, D_LOC2, 2'b10, 1'b0};
        tbl[5]  = '{1'b0, 8'h11, D_LOC2, 2'b00, 1'b0};
        tbl[6]  = '{1'b1, 8'hFF, D_IDLE, 2'b00, 1'b0};
        for (int i = 7; i < 11; i++)  tbl[i] = '{1'b1, 8'h11, D_MAL3, 2'b00, 1'b0};
        for (int i = 11; i < 15; i++) tbl[i] = '{1'b1, 8'h33, D_LOC2, 2'b00, 1'b0};
        tbl[15] = '{1'b1, 8'h11, D_LOC2, 2'b00, 1'b0};
        tbl[16] = '{1'b1, 8'hF1, D_LOCA, 2'b00, 1'b0};
        tbl[17] = '{1'b1, 8'hF1, D_LOCA, 2'b10, 1'b1};
        tbl[18] = '{1'b1, 8'h11, D_REM2, 2'b10, 1'b0};
        tbl[19] = '{1'b1, 8'h11, D_REM2, 2'b11, 1'b1};
        tbl[20] = '{1'b1, 8'h11, D_LOC2, 2'b11, 1'b0};
        tbl[21] = '{1'b0, 8'hFF, D_IDLE, 2'b00, 1'b0};

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].rst_n, tbl[i].c, tbl[i].d);
            check($sformatf("vec%0d", i), tbl[i].lf, tbl[i].fc);
        end

        // 3 local columns then the window expires; 2 more must not fault
        apply(1'b1, 8'h11, D_LOC2); check("win_seq1", 2'b00, 1'b0);
        apply(1'b1, 8'hF1, D_LOCA); check("win_seq2", 2'b00, 1'b0);
        for (int i = 0; i < 64; i++) begin
            apply(1'b1, 8'hFF, D_IDLE);
            check($sformatf("win_idle%0d", i), 2'b00, 1'b0);
        end
        apply(1'b1, 8'h11, D_LOC2); check("win_after", 2'b00, 1'b0);
        apply(1'b0, 8'hFF, D_IDLE); check("win_rst", 2'b00, 1'b0);

        // held local fault clears after exactly 128 idle columns
        apply(1'b1, 8'h11, D_LOC2);
        apply(1'b1, 8'h11, D_LOC2); check("clr_enter", 2'b10, 1'b1);
        for (int i = 0; i < 63; i++) begin
            apply(1'b1, 8'hFF, D_IDLE);
            check($sformatf("clr_idle%0d", i), 2'b10, 1'b0);
        end
        apply(1'b1, 8'hFF, D_IDLE); check("clr_exit", 2'b00, 1'b1);
        apply(1'b1, 8'hFF, D_IDLE); check("clr_after", 2'b00, 1'b0);

        // same-type sequence in FAULT restarts the clear window
        apply(1'b1, 8'h11, D_LOC2);
        apply(1'b1, 8'h11, D_LOC2); check("rst_win_enter", 2'b10, 1'b1);
        for (int i = 0; i < 40; i++) apply(1'b1, 8'hFF, D_IDLE);
        check("rst_win_mid", 2'b10, 1'b0);
        apply(1'b1, 8'hF1, D_LOCA); check("rst_win_refresh", 2'b10, 1'b0);
        for (int i = 0; i < 63; i++) apply(1'b1, 8'hFF, D_IDLE);
        check("rst_win_hold", 2'b10, 1'b0);
        apply(1'b1, 8'hFF, D_IDLE); check("rst_win_exit", 2'b00, 1'b1);
        apply(1'b0, 8'hFF, D_IDLE);

        // alternating types never reach the threshold
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 8'h11, (i % 2 == 0) ? D_REM2 : D_LOC2);
            check($sformatf("alt%0d", i), 2'b00, 1'b0);
        end
        apply(1'b1, 8'h11, D_REM2); check("alt_rem1", 2'b00, 1'b0);
        apply(1'b1, 8'h11, D_REM2); check("alt_rem2", 2'b11, 1'b1);
        apply(1'b0, 8'hFF, D_IDLE); check("alt_rst", 2'b00, 1'b0);

`ifdef RX_LINK_FAULT_STAT_EN
        for (int e = 0; e < 4; e++) begin
            apply(1'b1, 8'h11, (e < 3) ? D_LOC2 : D_REM2);
            apply(1'b1, 8'h11, (e < 3) ? D_LOC2 : D_REM2);
            for (int i = 0; i < 64; i++) apply(1'b1, 8'hFF, D_IDLE);
        end
        checks++;
        if (local_fault_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stat_local got=%0d exp=3", local_fault_cnt);
        end
        checks++;
        if (remote_fault_cnt !== 16'd1) begin
            failures++;
            $display("FAIL stat_remote got=%0d exp=1", remote_fault_cnt);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_link_fault_detect.md
RX_LINK_FAULT_DETECT -- requirements
Module: rx_link_fault_detect

Interface
REQ-001 Parameter COL_WINDOW, default 128: columns without a fault sequence before fault clears; also the window for reaching SEQ_THRESH.
REQ-002 Parameter SEQ_THRESH, default 4: same-type fault sequences needed to declare a fault.
REQ-003 rxclk  input  1  receive clock, all logic on rising edge.
REQ-004 reset_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 rxd64  input  64  XGMII data; lane k = rxd64[8k+7:8k]; column A = lanes 0-3, column B = lanes 4-7.
REQ-006 rxc8  input  8  XGMII control; bit k qualifies lane k.
REQ-007 link_fault  output  2  fault status: 2'b00 ok, 2'b10 local fault, 2'b11 remote fault; feeds the receive engine link_fault_in.
REQ-008 fault_change  output  1  one-cycle pulse whenever link_fault changes value.

Function
REQ-009 A column SHALL be a fault sequence only if its lane0 = 8'h9C with control=1, lanes1-3 control=0, lane1 = lane2 = 8'h00, and lane3 = 8'h01 (local) or 8'h02 (remote).
REQ-010 Any other column, including 8'h9C with other lane3 values or wrong control bits, SHALL be a non-fault column.
REQ-011 Each cycle, the block SHALL process column A, then column B, in order, so two state updates can occur per cycle.
REQ-012 The state machine SHALL have the states OK, COUNT and FAULT, a 2-bit seq_type, seq_cnt, and col_cnt (wide enough for COL_WINDOW).
REQ-013 In OK, a fault sequence of type T SHALL set seq_type=T, seq_cnt=1, col_cnt=0, and move to COUNT.
REQ-014 In COUNT, every column SHALL increment col_cnt.
REQ-015 In COUNT, a fault sequence of type seq_type SHALL increment seq_cnt; when seq_cnt reaches SEQ_THRESH, the block SHALL move to FAULT with col_cnt=0.
REQ-016 In COUNT, a fault sequence of the other type SHALL restart with seq_type=new, seq_cnt=1, col_cnt=0.
REQ-017 In COUNT, col_cnt reaching COL_WINDOW before the threshold SHALL return the block to OK.
REQ-018 In FAULT, a same-type sequence SHALL clear col_cnt.
REQ-019 In FAULT, an other-type sequence SHALL move to COUNT with the new type, seq_cnt=1, col_cnt=0, while link_fault is held.
REQ-020 In FAULT, COL_WINDOW consecutive non-fault columns SHALL return the block to OK.
REQ-021 link_fault SHALL be registered: it reflects the state after column B of cycle N at edge N+1 (latency 1 cycle); in FAULT it equals seq_type of the declaring sequence; otherwise it is 2'b00.
REQ-022 fault_change SHALL assert in the same cycle as the new link_fault value, for exactly 1 cycle.
REQ-023 If the threshold is reached in column A and column B is non-fault, the block SHALL still be in FAULT after column B.
REQ-024 col_cnt and seq_cnt SHALL saturate and never wrap.

Reset
REQ-025 With reset_n=0 at a rising edge, the block SHALL set state=OK, link_fault=2'b00, fault_change=0, seq_cnt=0, col_cnt=0, seq_type=2'b00, and counters to 0.
REQ-026 Reset mid-sequence or during FAULT SHALL clear the state on that edge without asserting fault_change.

Configuration
REQ-027 Macro RX_LINK_FAULT_STAT_EN, when defined, SHALL add outputs local_fault_cnt[15:0] and remote_fault_cnt[15:0].
REQ-028 Each counter SHALL increment on every entry into FAULT of its type and saturate at 16'hFFFF.
REQ-029 When the macro is undefined, these ports and their logic SHALL be absent, with no other behaviour change.

Verification
REQ-030 Drive 2 cycles, each with local sequences in both columns (rxc8=8'h11, rxd64=64'h0100009C_0100009C) -> link_fault=2'b10 and fault_change=1 at the edge after cycle 2.
REQ-031 Drive 3 local sequences, then 64 idle cycles (rxc8=8'hFF, rxd64=64'h07070707_07070707) -> link_fault stays 2'b00; a further 2 local sequences do not fault.
REQ-032 Drive a held local fault, then 63 idle cycles (still 2'b10), then a 64th idle cycle -> link_fault=2'b00 with a fault_change pulse.
REQ-033 Alternate local and remote sequences for 20 cycles -> link_fault stays 2'b00; then 2 cycles of remote pairs (lane3/7=8'h02) -> 2'b11.
REQ-034 Drive a malformed column (lane3=8'h03, or lane1 control=1) x8 -> no fault; drive reset_n=0 during FAULT -> 2'b00 at the next edge with fault_change=0.
REQ-035 With RX_LINK_FAULT_STAT_EN defined, drive 3 separate local fault episodes and 1 remote episode -> local_fault_cnt=3 and remote_fault_cnt=1.
